// File: rtl/cfa_diag_arbiter.sv
// rtl/cfa_diag_arbiter.sv - round-robin arbiter sharing one CFA diagonal-difference datapath among 4 channels
// Optional output clamp to [0, 2^DataBitWidth-1] when CFA_DIAG_CLAMP_EN is defined.
module cfa_diag_arbiter #(
  parameter int DataBitWidth = 12,
  parameter int NumReq       = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NumReq-1:0]                  req,
  input  logic [NumReq*4*DataBitWidth-1:0]   req_g,
  input  logic [NumReq*4*DataBitWidth-1:0]   req_rb,
  output logic [NumReq-1:0]                  gnt,
  output logic                               resp_valid,
  output logic [1:0]                         resp_id,
  output logic [DataBitWidth+2:0]            resp_data,
  input  logic                               resp_ready
);

  localparam int RW = DataBitWidth + 3;
  localparam int CW = 4 * DataBitWidth;

  logic                 stall;
  logic [1:0]           ptr;
  logic [1:0]           cand;
  logic [1:0]           gnt_idx;
  logic                 gnt_any;
  logic [CW-1:0]        g_sel;
  logic [CW-1:0]        rb_sel;
  logic [RW-1:0]        sum_g;
  logic [RW-1:0]        sum_rb;
  logic signed [RW-1:0] diff;
  logic                 s1_valid;
  logic [1:0]           s1_id;
  logic signed [RW-1:0] s1_op;
  logic signed [RW-1:0] s1_res;
  logic [RW-1:0]        s2_next;

  assign stall = resp_valid & ~resp_ready;

  // Search begins one past the last granted channel.
  always_comb begin
    gnt     = '0;
    gnt_idx = ptr;
    gnt_any = 1'b0;
    cand    = '0;
    if (!rst && !stall) begin
      for (int i = 1; i <= 4; i++) begin
        cand = ptr + 2'(i);
        if (!gnt_any && req[cand]) begin
          gnt_any = 1'b1;
          gnt_idx = cand;
        end
      end
      gnt[gnt_idx] = gnt_any;
    end
  end

  always_comb begin
    g_sel  = req_g[gnt_idx*CW +: CW];
    rb_sel = req_rb[gnt_idx*CW +: CW];
    sum_g  = '0;
    sum_rb = '0;
    for (int t = 0; t < 4; t++) begin
      sum_g  = sum_g  + {3'b000, g_sel[t*DataBitWidth +: DataBitWidth]};
      sum_rb = sum_rb + {3'b000, rb_sel[t*DataBitWidth +: DataBitWidth]};
    end
    diff = sum_g - sum_rb;
  end

  assign s1_res = s1_op >>> 2;

`ifdef CFA_DIAG_CLAMP_EN
  localparam logic [RW-1:0] MaxVal = {3'b000, {DataBitWidth{1'b1}}};

  always_comb begin
    s2_next = s1_res;
    if (s1_res[RW-1])
      s2_next = '0;
    else if ($unsigned(s1_res) > MaxVal)
      s2_next = MaxVal;
  end
`else
  assign s2_next = s1_res;
`endif

  // Both stages advance together; a stall freezes the whole pipe.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr        <= 2'd3;
      s1_valid   <= 1'b0;
      s1_id      <= '0;
      s1_op      <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_data  <= '0;
    end else begin
      if (gnt_any)
        ptr <= gnt_idx;
      if (!stall) begin
        s1_valid <= gnt_any;
        if (gnt_any) begin
          s1_id <= gnt_idx;
          s1_op <= diff;
        end
        resp_valid <= s1_valid;
        if (s1_valid) begin
          resp_id   <= s1_id;
          resp_data <= s2_next;
        end
      end
    end
  end

endmodule
